// File: rtl/updown_counter.sv
// Up/down wrap-around counter with pause and terminal-count flag.
// Define UPDOWN_COUNTER_SATURATE_EN to make the counter stop at its limits instead of wrapping.
module updown_counter #(
   parameter int WIDTH   = 5,
   parameter int MAX_VAL = 31
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             P_C,
   input  logic             U_D,
   output logic [WIDTH-1:0] Q,
   output logic             TC
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] next_q;
   logic             at_max;
   logic             above_max;
   logic             at_zero;

   assign at_max    = (Q == MAX_Q);
   assign above_max = (Q > MAX_Q);
   assign at_zero   = (Q == '0);

   // Out-of-range values recover to 0 going up and to MAX_VAL going down.
   always_comb begin
      next_q = Q;
      if (!P_C) begin
         if (U_D) begin
            if (above_max)
               next_q = '0;
            else if (at_max)
`ifdef UPDOWN_COUNTER_SATURATE_EN
               next_q = MAX_Q;
`else
               next_q = '0;
`endif
            else
               next_q = Q + WIDTH'(1);
         end else begin
            if (above_max)
               next_q = MAX_Q;
            else if (at_zero)
`ifdef UPDOWN_COUNTER_SATURATE_EN
               next_q = '0;
`else
               next_q = MAX_Q;
`endif
            else
               next_q = Q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         Q <= '0;
      else
         Q <= next_q;
   end

   assign TC = ~P_C & (U_D ? at_max : at_zero);

endmodule

// File: tb/tb_updown_counter.sv
// Testbench for updown_counter: directed and random steps against an arithmetic reference model.
// Checks a default instance (5 bit, 0..31) and a small instance (4 bit, 0..9) in parallel.
module tb_updown_counter;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       rst_small = 1'b1;
   logic       P_C = 1'b0;
   logic       U_D = 1'b1;
   logic [4:0] q;
   logic       tc;
   logic [3:0] q_small;
   logic       tc_small;

   int n_cmp = 0;
   int n_err = 0;
   int model_q = 0;
   int model_q_small = 0;

   updown_counter dut (
      .CLK(CLK), .RST(RST), .P_C(P_C), .U_D(U_D), .Q(q), .TC(tc)
   );

   updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut_small (
      .CLK(CLK), .RST(rst_small), .P_C(P_C), .U_D(U_D), .Q(q_small), .TC(tc_small)
   );

   always #5 CLK = ~CLK;

   // Counting is modulo (maxv+1), or clamped to 0..maxv in saturating builds.
   function automatic int modelNext(int cur, int maxv, bit pc, bit ud);
      if (pc) return cur;
`ifdef UPDOWN_COUNTER_SATURATE_EN
      if (ud) return (cur >= maxv) ? maxv : cur + 1;
      return (cur == 0) ? 0 : cur - 1;
`else
      if (ud) return (cur + 1) % (maxv + 1);
      return (cur + maxv) % (maxv + 1);
`endif
   endfunction

   function automatic int modelTc(int cur, int maxv, bit pc, bit ud);
      if (pc) return 0;
      return ud ? int'(cur == maxv) : int'(cur == 0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive inputs at the falling edge, check TC before the rising edge and Q just after it.
   task automatic applyStimulus(input bit rst1, input bit rst2, input bit pc, input bit ud);
      @(negedge CLK);
      RST = rst1;
      rst_small = rst2;
      P_C = pc;
      U_D = ud;
      #1;
      if (rst1) model_q = 0;
      if (rst2) model_q_small = 0;
      checkOutput("tc", 32'(tc), 32'(modelTc(model_q, 31, pc, ud)));
      checkOutput("tc_small", 32'(tc_small), 32'(modelTc(model_q_small, 9, pc, ud)));
      @(posedge CLK);
      #1;
      if (!rst1) model_q = modelNext(model_q, 31, pc, ud);
      if (!rst2) model_q_small = modelNext(model_q_small, 9, pc, ud);
      checkOutput("q", 32'(q), 32'(model_q));
      checkOutput("q_small", 32'(q_small), 32'(model_q_small));
   endtask

   initial begin
      bit r_rst;
      bit r_pc;
      bit r_ud;

      // Reset state
      #2;
      checkOutput("reset_q", 32'(q), 32'd0);
      checkOutput("reset_tc", 32'(tc), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

      // Count up to 17, then assert reset between edges
      for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("q_before_async", 32'(q), 32'd17);
      #2;
      RST = 1'b1;
      #1;
      model_q = 0;
      checkOutput("async_reset_q", 32'(q), 32'd0);

      // Hold reset with direction toggling
      for (int i = 0; i < 35; i++) applyStimulus(1'b1, 1'b1, 1'b0, bit'(i % 2));

      // Up count through the wrap
      for (int i = 0; i < 35; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("up_wrap_end", 32'(q), 32'd3);

      // Down count from 0
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("down_wrap_end", 32'(q), 32'd29);

      // Pause at 10
      for (int i = 0; i < 19; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("pause_start", 32'(q), 32'd10);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("pause_hold", 32'(q), 32'd10);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("pause_release", 32'(q), 32'd11);

      // Direction switch at 5
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("dir_at_5", 32'(q), 32'd5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("dir_switch", 32'(q), 32'd4);

      // Small instance: 0..9 up count
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic on both instances
      for (int i = 0; i < 300; i++) begin
         r_rst = ($urandom_range(0, 29) == 0);
         r_pc  = ($urandom_range(0, 3) == 0);
         r_ud  = bit'($urandom_range(0, 1));
         applyStimulus(r_rst, 1'b0, r_pc, r_ud);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parameterised synchronous up/down counter with a pause control, wrap-around at a programmable upper bound and a terminal-count flag. Default configuration is a 5-bit counter covering 0..31. It sits in the exam-project datapath as a generic event/sequence counter driven directly by board controls (direction switch, pause switch).

## Interface
- WIDTH, 5, counter width in bits (legal 2..16).
- MAX_VAL, 31, highest count value; must satisfy 1 ≤ MAX_VAL ≤ 2^WIDTH−1.
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset; forces all state to reset values immediately, independent of CLK.
- P_C  input  1  pause control: 1 = hold current count, 0 = count.
- U_D  input  1  direction: 1 = count up, 0 = count down.
- Q    output WIDTH  current count, registered.
- TC   output 1  terminal count: combinational, 1 when the next enabled edge will wrap (Q==MAX_VAL with U_D=1, or Q==0 with U_D=0), and P_C=0.

## Operation
- Reset (RST=1): Q=0 asynchronously. Held at 0 for as long as RST is high, with no counting. TC is evaluated from Q=0 and the inputs, so it equals ~U_D & ~P_C during reset.
- On each rising CLK with RST=0:
  - P_C=1: Q holds its value. This takes priority over U_D.
  - P_C=0, U_D=1: if Q==MAX_VAL, Q becomes 0. Otherwise Q becomes Q+1.
  - P_C=0, U_D=0: if Q==0, Q becomes MAX_VAL. Otherwise Q becomes Q−1.
- Q never leaves 0..MAX_VAL. All arithmetic is modulo (MAX_VAL+1) and is performed at WIDTH bits, with no carry-out port.
- A direction change takes effect on the first edge after U_D changes. No idle cycle is inserted and there is no extra step.
- P_C and U_D are synchronous inputs. They are sampled only at rising CLK and have no effect between edges.
- There is no illegal state. If Q were somehow above MAX_VAL, the next enabled count edge loads 0 (up) or MAX_VAL (down).

## Timing
- Latency is one cycle: inputs sampled at edge n are reflected on Q after edge n.
- Q is registered and glitch-free. TC is combinational from Q, U_D and P_C.
- Reset assertion is asynchronous and takes effect within the same simulation time step.
- Reset release is synchronous to CLK:
  - The first edge with RST=0 performs a normal count from Q=0.
  - Down counting therefore yields MAX_VAL on that first edge.
- Asserting reset mid-count immediately clears Q. Any pending edge in the same time step is ignored.

## Configuration
- UPDOWN_COUNTER_SATURATE_EN, when defined, switches the counter to saturating mode:
  - Counting up at MAX_VAL holds MAX_VAL.
  - Counting down at 0 holds 0.
  - TC stays 1 while pinned at the limit in the active direction and P_C=0.
- When undefined (the default), the wrap-around behaviour described in Operation applies.
- Reset, pause and latency are identical in both modes.

## Test plan
- Reset and hold: assert RST=1 asynchronously mid-cycle with Q=17 → Q=0 immediately. Keep RST=1 for 35 clocks with U_D toggling → Q stays 0.
- Up count and wrap (defaults): release reset, set P_C=0, U_D=1, apply 35 clocks → Q runs 1,2,…,31,0,1,2,3. TC=1 exactly while Q=31.
- Down count and wrap: from Q=0, set U_D=0 and apply 3 clocks → Q runs 31,30,29. TC=1 at Q=0 before the first edge.
- Pause: with Q=10, set P_C=1 and apply 5 clocks with U_D=1, then 5 clocks with U_D=0 → Q stays 10 throughout and TC=0. Set P_C=0, U_D=1, apply 1 clock → Q=11.
- Direction switch: at Q=5 counting up, set U_D=0 before an edge → the next edge gives Q=4, with no skipped or repeated value.
- Parameter and saturate check: with WIDTH=4, MAX_VAL=9 and up counting from 0 → Q reaches 9 then 0. With UPDOWN_COUNTER_SATURATE_EN defined → Q stays at 9 and TC=1.
